// File: rtl/bf16_add_arbiter.sv
// Round-robin arbiter that shares one combinational bfloat16 adder among NUM_REQ
// requesters and returns each registered sum to the requester that issued it.
module bf16_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [16*NUM_REQ-1:0]   req_a,
  input  logic [16*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]      resp_valid,
  input  logic [NUM_REQ-1:0]      resp_ready,
  output logic [15:0]             resp_sum,
  output logic [15:0]             add_a,
  output logic [15:0]             add_b,
  input  logic [15:0]             add_sum,
  output logic                    busy,
  output logic [CNT_W-1:0]        op_count
);

  // state | meaning
  // IDLE  | result register empty
  // HOLD  | res_q held for requester owner
  typedef enum logic {IDLE, HOLD} state_t;

  localparam int IDX_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] rr_ptr, owner, grant;
  logic [IDX_W:0]   cand;
  logic [15:0]      res_q;
  logic             any_req, resp_fire, can_issue, gnt_vld;

  // Search starts one past the last winner so priority rotates.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      if (!any_req && req_valid[cand[IDX_W-1:0]]) begin
        any_req = 1'b1;
        grant   = cand[IDX_W-1:0];
      end
    end
  end

  assign resp_fire = (state == HOLD) && resp_ready[owner];
  assign can_issue = (state == IDLE) || resp_fire;
  // Gated with rst_n so no grant is advertised while reset is asserted.
  assign gnt_vld   = rst_n && can_issue && any_req;

  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    resp_valid = '0;
    add_a      = '0;
    add_b      = '0;
    if (gnt_vld) begin
      state_nxt  = HOLD;
      req_ready  = NUM_REQ'(1) << grant;
      add_a      = req_a[{grant, 4'b0000} +: 16];
      add_b      = req_b[{grant, 4'b0000} +: 16];
    end else if (resp_fire) begin
      state_nxt  = IDLE;
    end
    if (state == HOLD) resp_valid = NUM_REQ'(1) << owner;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= IDX_W'(NUM_REQ - 1);
      owner    <= '0;
      res_q    <= '0;
      op_count <= '0;
    end else begin
      state <= state_nxt;
      if (gnt_vld) begin
        res_q  <= add_sum;
        owner  <= grant;
        rr_ptr <= grant;
      end
      if (resp_fire) op_count <= op_count + 1'b1;
    end
  end

  assign resp_sum = res_q;
  assign busy     = (state == HOLD);

endmodule

// File: tb/tb_bf16_add_arbiter.sv
// Self-checking bench for bf16_add_arbiter: directed scenarios plus a randomized
// run checked against a cycle-level behavioural model of the arbitration rules.
module tb_bf16_add_arbiter;
  localparam int N  = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid, req_ready, resp_valid, resp_ready;
  logic [16*N-1:0] req_a, req_b;
  logic [15:0]   resp_sum, add_a, add_b, add_sum;
  logic          busy;
  logic [CW-1:0] op_count;
  logic          use_real = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // Same-sign normal bf16 add with truncation; enough for the smoke case.
  function automatic logic [15:0] bf16_add(input logic [15:0] x, input logic [15:0] y);
    logic [7:0] ex, ey, d;
    logic [8:0] mx, my, s;
    logic [15:0] t;
    if (y[14:7] > x[14:7]) begin t = x; x = y; y = t; end
    ex = x[14:7]; ey = y[14:7];
    mx = {2'b01, x[6:0]}; my = {2'b01, y[6:0]};
    d  = ex - ey;
    my = (d > 8'd8) ? 9'd0 : (my >> d);
    s  = mx + my;
    if (s[8]) return {x[15], ex + 8'd1, s[7:1]};
    return {x[15], ex, s[6:0]};
  endfunction

  assign add_sum = use_real ? bf16_add(add_a, add_b) : add_a + add_b;

  always #5 clk = ~clk;

  bf16_add_arbiter #(.NUM_REQ(N), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_sum(resp_sum),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .busy(busy), .op_count(op_count)
  );

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; resp_ready = '0; req_a = '0; req_b = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    req_valid = 4'b0001; resp_ready = 4'b1111;
    @(negedge clk);
    req_valid = 4'b0010;
    @(negedge clk);
    req_valid = 4'b0000; resp_ready = 4'b0000;
    #1;
    n_tests++; if (op_count !== 16'd1) begin n_fail++; $display("FAIL pre_reset_count: got %h expected %h", op_count, 16'd1); end
    n_tests++; if (resp_valid !== 4'b0010) begin n_fail++; $display("FAIL pre_reset_hold: got %b expected %b", resp_valid, 4'b0010); end
    req_valid = 4'b1111;
    rst_n = 1'b0;
    #1;
    n_tests++; if (resp_valid !== 4'b0000) begin n_fail++; $display("FAIL rst_resp_valid: got %b expected %b", resp_valid, 4'b0000); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected %b", busy, 1'b0); end
    n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_req_ready: got %b expected %b", req_ready, 4'b0000); end
    n_tests++; if (resp_sum !== 16'h0000) begin n_fail++; $display("FAIL rst_resp_sum: got %h expected %h", resp_sum, 16'h0000); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++; if (op_count !== 16'd0) begin n_fail++; $display("FAIL rst_op_count: got %h expected %h", op_count, 16'd0); end
    n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rst_first_prio: got %b expected %b", req_ready, 4'b0001); end
  endtask

  task automatic test_single();
    do_reset();
    resp_ready = 4'b1111;
    req_valid = 4'b0100; req_a[32 +: 16] = 16'h0003; req_b[32 +: 16] = 16'h0004;
    #1;
    n_tests++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_grant: got %b expected %b", req_ready, 4'b0100); end
    n_tests++; if (add_a !== 16'h0003 || add_b !== 16'h0004) begin n_fail++; $display("FAIL single_operands: got %h/%h expected 0003/0004", add_a, add_b); end
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL single_ready_drop: got %b expected %b", req_ready, 4'b0000); end
    n_tests++; if (resp_valid !== 4'b0100) begin n_fail++; $display("FAIL single_resp_valid: got %b expected %b", resp_valid, 4'b0100); end
    n_tests++; if (resp_sum !== 16'h0007) begin n_fail++; $display("FAIL single_resp_sum: got %h expected %h", resp_sum, 16'h0007); end
    n_tests++; if (op_count !== 16'd0) begin n_fail++; $display("FAIL single_count_before: got %h expected %h", op_count, 16'd0); end
    @(negedge clk); #1;
    n_tests++; if (resp_valid !== 4'b0000) begin n_fail++; $display("FAIL single_resp_done: got %b expected %b", resp_valid, 4'b0000); end
    n_tests++; if (op_count !== 16'd1) begin n_fail++; $display("FAIL single_count_after: got %h expected %h", op_count, 16'd1); end
  endtask

  task automatic test_round_robin();
    do_reset();
    resp_ready = 4'b1111; req_valid = 4'b1111;
    for (int i = 0; i < N; i++) begin
      req_a[16*i +: 16] = 16'(i); req_b[16*i +: 16] = 16'h0100;
    end
    for (int k = 0; k < 9; k++) begin
      #1;
      n_tests++; if (req_ready !== 4'(1 << (k % N))) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, req_ready, 4'(1 << (k % N))); end
      if (k > 0) begin
        n_tests++; if (resp_valid !== 4'(1 << ((k - 1) % N))) begin n_fail++; $display("FAIL rr_resp_valid[%0d]: got %b expected %b", k, resp_valid, 4'(1 << ((k - 1) % N))); end
        n_tests++; if (resp_sum !== 16'(16'h0100 + (k - 1) % N)) begin n_fail++; $display("FAIL rr_resp_sum[%0d]: got %h expected %h", k, resp_sum, 16'(16'h0100 + (k - 1) % N)); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    resp_ready = 4'b1111; req_valid = 4'b0010;
    req_a[16 +: 16] = 16'h0055;
    #1;
    n_tests++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_grant1: got %b expected %b", req_ready, 4'b0010); end
    @(negedge clk);
    resp_ready = 4'b1101; req_valid = 4'b1001;
    req_a[0 +: 16] = 16'h0010; req_a[48 +: 16] = 16'h0030;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_stall_ready[%0d]: got %b expected %b", k, req_ready, 4'b0000); end
      n_tests++; if (resp_sum !== 16'h0055 || resp_valid !== 4'b0010) begin n_fail++; $display("FAIL bp_stall_resp[%0d]: got %h/%b expected 0055/0010", k, resp_sum, resp_valid); end
      @(negedge clk);
    end
    resp_ready = 4'b1111;
    #1;
    n_tests++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_release_grant: got %b expected %b", req_ready, 4'b1000); end
    n_tests++; if (add_a !== 16'h0030) begin n_fail++; $display("FAIL bp_release_operand: got %h expected %h", add_a, 16'h0030); end
    @(negedge clk);
    req_valid = 4'b0001;
    #1;
    n_tests++; if (resp_valid !== 4'b1000 || resp_sum !== 16'h0030) begin n_fail++; $display("FAIL bp_resp3: got %b/%h expected 1000/0030", resp_valid, resp_sum); end
    n_tests++; if (op_count !== 16'd1) begin n_fail++; $display("FAIL bp_count: got %h expected %h", op_count, 16'd1); end
    n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_next_grant: got %b expected %b", req_ready, 4'b0001); end
  endtask

  task automatic test_random();
    logic [N-1:0] pend;
    logic [15:0]  pa [N];
    logic [15:0]  pb [N];
    logic         m_hold, can;
    int           m_owner, m_rr, g;
    logic [15:0]  m_res, m_cnt;
    logic [N-1:0] exp_ready;
    do_reset();
    pend = '0; m_hold = 1'b0; m_owner = 0; m_rr = N - 1; m_res = '0; m_cnt = '0;
    for (int i = 0; i < N; i++) begin pa[i] = '0; pb[i] = '0; end
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1; pa[i] = 16'($urandom); pb[i] = 16'($urandom);
        end else if (pend[i] && $urandom_range(0, 15) == 0) begin
          pend[i] = 1'b0;
        end
        req_a[16*i +: 16] = pa[i]; req_b[16*i +: 16] = pb[i];
      end
      req_valid  = pend;
      resp_ready = 4'($urandom_range(0, 15));
      can = !m_hold || resp_ready[m_owner];
      g = -1;
      for (int k = 1; k <= N; k++) if (g < 0 && req_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
      exp_ready = (can && g >= 0) ? 4'(1 << g) : 4'b0000;
      #1;
      n_tests++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_req_ready[%0d]: got %b expected %b", c, req_ready, exp_ready); end
      n_tests++; if (resp_valid !== (m_hold ? 4'(1 << m_owner) : 4'b0000)) begin n_fail++; $display("FAIL rnd_resp_valid[%0d]: got %b expected %b", c, resp_valid, m_hold ? 4'(1 << m_owner) : 4'b0000); end
      n_tests++; if (resp_sum !== m_res) begin n_fail++; $display("FAIL rnd_resp_sum[%0d]: got %h expected %h", c, resp_sum, m_res); end
      n_tests++; if (busy !== m_hold) begin n_fail++; $display("FAIL rnd_busy[%0d]: got %b expected %b", c, busy, m_hold); end
      n_tests++; if (op_count !== m_cnt) begin n_fail++; $display("FAIL rnd_op_count[%0d]: got %h expected %h", c, op_count, m_cnt); end
      n_tests++; if (add_a !== ((exp_ready != 0) ? pa[g] : 16'h0)) begin n_fail++; $display("FAIL rnd_add_a[%0d]: got %h expected %h", c, add_a, (exp_ready != 0) ? pa[g] : 16'h0); end
      if (m_hold && resp_ready[m_owner]) m_cnt = m_cnt + 16'd1;
      if (exp_ready != 0) begin
        m_res = pa[g] + pb[g]; m_owner = g; m_rr = g; m_hold = 1'b1; pend[g] = 1'b0;
      end else if (m_hold && resp_ready[m_owner]) begin
        m_hold = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    req_valid = 4'b0001; resp_ready = 4'b1111;
    repeat (65536) @(negedge clk);
    #1;
    n_tests++; if (op_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_full: got %h expected %h", op_count, 16'hFFFF); end
    @(negedge clk); #1;
    n_tests++; if (op_count !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero: got %h expected %h", op_count, 16'h0000); end
  endtask

  task automatic test_real_adder();
    logic [15:0] ref_sum;
    ref_sum = bf16_add(16'h3F80, 16'h3F80);
    n_tests++; if (ref_sum !== 16'h4000) begin n_fail++; $display("FAIL adder_only: got %h expected %h", ref_sum, 16'h4000); end
    use_real = 1'b1;
    do_reset();
    resp_ready = 4'b1111; req_valid = 4'b1000;
    req_a[48 +: 16] = 16'h3F80; req_b[48 +: 16] = 16'h3F80;
    #1;
    n_tests++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL real_grant: got %b expected %b", req_ready, 4'b1000); end
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    n_tests++; if (resp_valid !== 4'b1000) begin n_fail++; $display("FAIL real_route: got %b expected %b", resp_valid, 4'b1000); end
    n_tests++; if (resp_sum !== ref_sum) begin n_fail++; $display("FAIL real_sum: got %h expected %h", resp_sum, ref_sum); end
    use_real = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_random();
    test_wrap();
    test_real_adder();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
